axis_packetizer: RTL
====================

# axis_packetizer

Stream stage directly downstream of the AXI4-Stream user processing core's master port. It regroups the core's untermined 32-bit output beats into fixed-length packets by inserting TLAST every `cfg_pkt_len` beats. It buffers the beats in a small FIFO so downstream backpressure does not stall the core for short bursts. It also provides a completed-packet counter for the register bank.

## Interface
Parameters:
- `DATA_WIDTH`, 32, TDATA width in bits.
- `USER_WIDTH`, 8, TUSER width, carried through unchanged.
- `LEN_WIDTH`, 16, width of the packet-length config and beat counter.
- `FIFO_DEPTH`, 16, buffer entries; power of two, ≥2.

Ports:
- `ACLK`  in  1  the only clock; all logic on rising edge.
- `ARESETN`  in  1  reset, synchronous, active-low. Sampled on `ACLK` rising edge.
- `cfg_enable`  in  1  1 = accept input; 0 = stop at next packet boundary.
- `cfg_pkt_len`  in  LEN_WIDTH  beats per packet; 0 is treated as 1.
- `s_axis_tdata`  in  DATA_WIDTH  input beat data.
- `s_axis_tuser`  in  USER_WIDTH  input sideband.
- `s_axis_tvalid`  in  1  input beat valid.
- `s_axis_tready`  out  1  block can accept a beat.
- `m_axis_tdata`  out  DATA_WIDTH  output beat data.
- `m_axis_tuser`  out  USER_WIDTH  output sideband.
- `m_axis_tlast`  out  1  last beat of packet.
- `m_axis_tvalid`  out  1  output beat valid.
- `m_axis_tready`  in  1  downstream accepts.
- `stat_pkt_count`  out  32  packets fully emitted; wraps 0xFFFFFFFF→0.
- `stat_busy`  out  1  state ≠ IDLE or FIFO non-empty.

## Operation
- **FSM states: IDLE, RUN, STOPPING.**
  - IDLE→RUN when `cfg_enable`=1.
  - RUN→IDLE when `cfg_enable`=0 and `beat_cnt`=0.
  - RUN→STOPPING when `cfg_enable`=0 and `beat_cnt`≠0.
  - STOPPING→IDLE on the accepted beat that carries TLAST.
  - STOPPING ignores `cfg_enable` re-assertion until it reaches IDLE.
- **Input acceptance:** `s_axis_tready` = (state≠IDLE) AND NOT fifo_full. An input handshake is `s_axis_tvalid` AND `s_axis_tready`.
- **Packet length latch:** `len_q` is latched from `cfg_pkt_len` (0→1) on every input handshake with `beat_cnt`=0. A length change mid-packet takes effect at the next packet.
- **TLAST insertion:** the FIFO word is {tlast, tuser, tdata}, with tlast = (`beat_cnt` = len−1). The length used is `len_q`, or the value being latched when `beat_cnt`=0.
  - `beat_cnt` increments per handshake and clears to 0 on the tlast beat.
  - `cfg_pkt_len`=1 marks every beat as last.
- **FIFO:** first-word-fall-through, `FIFO_DEPTH` entries.
  - Pointers are log2(FIFO_DEPTH)+1 bits wide; full = MSBs differ and LSBs are equal.
  - Simultaneous read and write are allowed at any occupancy except full, where the write is blocked by tready.
- **Output:** `m_axis_tvalid` = FIFO not empty. `m_axis_*` are held stable while tvalid=1 and tready=0.
- **Counter:** `stat_pkt_count` increments on each output handshake with `m_axis_tlast`=1.

## Timing
- Reset (`ARESETN`=0 at an edge):
  - state=IDLE; pointers, `beat_cnt`, `len_q` and `stat_pkt_count` all 0.
  - `s_axis_tready`, `m_axis_tvalid`, `m_axis_tlast` and `stat_busy` are 0; `m_axis_tdata` and `m_axis_tuser` are 0.
  - FIFO contents are discarded.
  - Reset mid-packet drops the partial packet with no TLAST emitted; the next packet starts at `beat_cnt`=0.
- `s_axis_tready` is 0 in the first cycle after reset release. It rises one cycle after `cfg_enable` is sampled 1.
- Latency: a beat accepted at edge N is presented on `m_axis` with tvalid=1 after edge N (cycle N+1). This gives one cycle of latency when the FIFO was empty.
- Throughput: 1 beat/cycle sustained with `m_axis_tready`=1.
- Full: `s_axis_tready` drops in the cycle after the write that fills the FIFO. It rises in the cycle after the next read.
- `stat_pkt_count` updates the cycle after the TLAST output handshake.

## Test plan
- **Basic packetizing:** reset, `cfg_enable`=1, `cfg_pkt_len`=4, drive 8 beats 0x01..0x08 with `m_axis_tready`=1 → output 0x01..0x08 in order, tlast on 0x04 and 0x08, `stat_pkt_count`=2, first output one cycle after first accept.
- **Length edge cases:** `cfg_pkt_len`=0 then 1, 3 beats each → every beat has tlast=1 and `stat_pkt_count`=6. Change len 4→2 after beat 2 of a packet → that packet still ends at beat 4, and the next packet has 2 beats.
- **Backpressure and full:** `FIFO_DEPTH`=16, `m_axis_tready`=0, continuous input → exactly 16 beats accepted, `s_axis_tready`=0 thereafter, `m_axis_tdata` stable. Release tready → all 16 beats drain in order with no loss or duplication.
- **Graceful stop:** `cfg_pkt_len`=5, drop `cfg_enable` after 2 beats → 3 further beats accepted (last with tlast), then state IDLE, `s_axis_tready`=0; `stat_busy`=0 once drained.
- **Reset mid-operation:** 3 beats of a 4-beat packet in the FIFO, assert `ARESETN`=0 for one edge → `m_axis_tvalid`=0 next cycle, `stat_pkt_count`=0. The following 4 beats form one packet with tlast on beat 4.
- **Random soak:** random `s_axis_tvalid`/`m_axis_tready` (50%), `cfg_pkt_len`=7, 1000 beats → scoreboard matches data/user order, tlast every 7th beat, `stat_pkt_count`=142.

Source files
------------

// File: rtl/axis_packetizer_if.sv
// -----------------------------------------------------------------------------
// axis_packetizer_if
//
// Purpose:
//   AXI4-Stream bundle shared by the packetizer's input and output sides.
//
// Signals:
//   tdata  [DATA_WIDTH-1:0]  beat data
//   tuser  [USER_WIDTH-1:0]  sideband, carried through unchanged
//   tlast                    last beat of a packet (output side only)
//   tvalid                   beat valid (source -> sink)
//   tready                   sink can accept (sink -> source)
//
// Modports:
//   master  used by the block that sources beats (drives tdata/tuser/tlast/tvalid)
//   slave   used by the block that sinks beats (drives tready). The upstream
//           core's stream carries no packet framing, so the slave view omits tlast.
// -----------------------------------------------------------------------------
interface axis_packetizer_if #(
    parameter int DATA_WIDTH = 32,
    parameter int USER_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] tdata;
    logic [USER_WIDTH-1:0] tuser;
    logic                  tlast;
    logic                  tvalid;
    logic                  tready;

    modport master (
        output tdata,
        output tuser,
        output tlast,
        output tvalid,
        input  tready
    );

    modport slave (
        input  tdata,
        input  tuser,
        input  tvalid,
        output tready
    );
endinterface

// File: rtl/axis_packetizer.sv
// -----------------------------------------------------------------------------
// axis_packetizer
//
// Purpose:
//   Regroups an unterminated AXI4-Stream of beats into fixed-length packets by
//   marking every cfg_pkt_len-th beat with TLAST. Beats pass through a small
//   first-word-fall-through FIFO so short bursts of downstream backpressure do
//   not stall the upstream core. Completed output packets are counted.
//
// Ports:
//   ACLK            in   clock, all logic on the rising edge
//   ARESETN         in   synchronous active-low reset
//   cfg_enable      in   1 = accept input; 0 = stop at the next packet boundary
//   cfg_pkt_len     in   beats per packet (0 behaves as 1)
//   s_axis          slave  input stream  (tdata, tuser, tvalid / tready)
//   m_axis          master output stream (tdata, tuser, tlast, tvalid / tready)
//   stat_pkt_count  out  packets fully emitted, wraps at 2^32
//   stat_busy       out  FSM not idle, or beats still buffered
// -----------------------------------------------------------------------------
module axis_packetizer #(
    parameter int DATA_WIDTH = 32,
    parameter int USER_WIDTH = 8,
    parameter int LEN_WIDTH  = 16,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                 ACLK,
    input  logic                 ARESETN,
    input  logic                 cfg_enable,
    input  logic [LEN_WIDTH-1:0] cfg_pkt_len,
    axis_packetizer_if.slave     s_axis,
    axis_packetizer_if.master    m_axis,
    output logic [31:0]          stat_pkt_count,
    output logic                 stat_busy
);

    // Address bits index the storage; the extra pointer MSB tells a full FIFO
    // apart from an empty one when the address bits are equal.
    localparam int ADDR_WIDTH = $clog2(FIFO_DEPTH);
    localparam int PTR_WIDTH  = ADDR_WIDTH + 1;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN      = 2'd1,
        STOPPING = 2'd2
    } state_t;

    typedef struct packed {
        logic                  last;
        logic [USER_WIDTH-1:0] user;
        logic [DATA_WIDTH-1:0] data;
    } fifo_word_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t                 state;
    logic [PTR_WIDTH-1:0]   wrPtr;
    logic [PTR_WIDTH-1:0]   rdPtr;
    logic [LEN_WIDTH-1:0]   beatCnt;
    logic [LEN_WIDTH-1:0]   lenQ;
    fifo_word_t             fifoMem [FIFO_DEPTH];

    // Registered output stage: always holds a copy of the FIFO head.
    logic                   mValid;
    fifo_word_t             mWord;
    logic [31:0]            pktCount;

    // ------------------------------------------------------------------
    // Next-state datapath
    // ------------------------------------------------------------------
    logic                   fifoFull;
    logic                   sReady;
    logic                   inFire;
    logic                   outFire;
    logic [LEN_WIDTH-1:0]   cfgLen;
    logic [LEN_WIDTH-1:0]   curLen;
    logic                   beatLast;
    logic [LEN_WIDTH-1:0]   beatCntNext;
    logic [PTR_WIDTH-1:0]   wrPtrNext;
    logic [PTR_WIDTH-1:0]   rdPtrNext;
    logic                   emptyNext;
    fifo_word_t             inWord;
    fifo_word_t             headNext;

    assign fifoFull = (wrPtr[PTR_WIDTH-1] != rdPtr[PTR_WIDTH-1]) &&
                      (wrPtr[ADDR_WIDTH-1:0] == rdPtr[ADDR_WIDTH-1:0]);

    // Decoded from registers only, so there is no combinational path from
    // any input to s_axis.tready.
    assign sReady  = (state != IDLE) && !fifoFull;
    assign inFire  = s_axis.tvalid && sReady;
    assign outFire = mValid && m_axis.tready;

    // NOTE: every signal assigned in this block gets a default at the top, so
    // no path leaves one unassigned and no latch is inferred.
    always_comb begin
        cfgLen      = (cfg_pkt_len == '0) ? LEN_WIDTH'(1) : cfg_pkt_len;
        curLen      = lenQ;
        beatLast    = 1'b0;
        beatCntNext = beatCnt;
        wrPtrNext   = wrPtr;
        rdPtrNext   = rdPtr;
        emptyNext   = 1'b1;
        inWord      = '0;
        headNext    = '0;

        // The first beat of a packet uses the length being latched right now,
        // so a new cfg_pkt_len applies from the very first beat of a packet
        // and never mid-packet.
        if (beatCnt == '0) begin
            curLen = cfgLen;
        end
        beatLast = (beatCnt == (curLen - LEN_WIDTH'(1)));

        inWord.last = beatLast;
        inWord.user = s_axis.tuser;
        inWord.data = s_axis.tdata;

        if (inFire) begin
            beatCntNext = beatLast ? '0 : (beatCnt + LEN_WIDTH'(1));
            wrPtrNext   = wrPtr + PTR_WIDTH'(1);
        end
        if (outFire) begin
            rdPtrNext = rdPtr + PTR_WIDTH'(1);
        end

        emptyNext = (wrPtrNext == rdPtrNext);

        // Head after this edge: the word being written bypasses the storage
        // when it lands exactly at the next read position (FIFO was empty, or
        // its only word is being popped now).
        if (!emptyNext) begin
            if (inFire && (wrPtr == rdPtrNext)) begin
                headNext = inWord;
            end else begin
                headNext = fifoMem[rdPtrNext[ADDR_WIDTH-1:0]];
            end
        end
    end

    // ------------------------------------------------------------------
    // FIFO storage
    // ------------------------------------------------------------------
    // NOTE: the storage array has no reset; emptiness is defined by the
    // pointers alone, and leaving it unreset lets it map onto plain RAM/LUTs.
    always_ff @(posedge ACLK) begin
        if (inFire) begin
            fifoMem[wrPtr[ADDR_WIDTH-1:0]] <= inWord;
        end
    end

    // ------------------------------------------------------------------
    // FSM, pointers, beat counter, output stage and packet counter
    // ------------------------------------------------------------------
    // NOTE: all state here is updated with non-blocking assignments so every
    // register samples the pre-edge values, independent of statement order.
    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            state    <= IDLE;
            wrPtr    <= '0;
            rdPtr    <= '0;
            beatCnt  <= '0;
            lenQ     <= '0;
            mValid   <= 1'b0;
            mWord    <= '0;
            pktCount <= '0;
        end else begin
            // Stopping is judged on the count after this edge's beat, so a
            // beat accepted in the same cycle cfg_enable falls is still
            // closed out with TLAST before the input shuts.
            case (state)
                IDLE: begin
                    if (cfg_enable) begin
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (!cfg_enable) begin
                        state <= (beatCntNext == '0) ? IDLE : STOPPING;
                    end
                end
                STOPPING: begin
                    // cfg_enable is deliberately ignored until the open
                    // packet has received its TLAST beat.
                    if (beatCntNext == '0) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase

            wrPtr   <= wrPtrNext;
            rdPtr   <= rdPtrNext;
            beatCnt <= beatCntNext;

            if (inFire && (beatCnt == '0)) begin
                lenQ <= cfgLen;
            end

            mValid <= !emptyNext;
            mWord  <= headNext;

            if (outFire && mWord.last) begin
                pktCount <= pktCount + 32'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign s_axis.tready  = sReady;

    assign m_axis.tvalid  = mValid;
    assign m_axis.tdata   = mWord.data;
    assign m_axis.tuser   = mWord.user;
    assign m_axis.tlast   = mWord.last;

    assign stat_pkt_count = pktCount;
    assign stat_busy      = (state != IDLE) || mValid;

endmodule
